// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: exception FSM encoding,
// stage-index width helper and default sizing constants.
package gemini_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StFlush = 2'd2
  } exc_state_e;

  localparam int unsigned DefStages      = 6;
  localparam int unsigned DefFlushCycles = 1;

  // Width of a stage index; never narrower than one bit.
  function automatic int unsigned stage_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
// The wdog_trip signal exists only when STALL_WDOG_EN is defined.
interface pipe_hazard_ctrl_if
  import gemini_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = DefStages
);
  localparam int unsigned SW = stage_w(STAGES);

  logic [STAGES-1:0] stall_req;
  logic [STAGES-1:0] br_flush_req;
  logic              mem_busy;
  logic              exc_req;
  logic [SW-1:0]     exc_stage;
  logic [STAGES-1:0] stall_o;
  logic [STAGES-1:0] flush_o;
  logic              exc_redirect;
  logic              exc_busy;
`ifdef STALL_WDOG_EN
  logic              wdog_trip;

  modport master (
    output stall_req, br_flush_req, mem_busy, exc_req, exc_stage,
    input  stall_o, flush_o, exc_redirect, exc_busy, wdog_trip
  );
  modport slave (
    input  stall_req, br_flush_req, mem_busy, exc_req, exc_stage,
    output stall_o, flush_o, exc_redirect, exc_busy, wdog_trip
  );
`else
  modport master (
    output stall_req, br_flush_req, mem_busy, exc_req, exc_stage,
    input  stall_o, flush_o, exc_redirect, exc_busy
  );
  modport slave (
    input  stall_req, br_flush_req, mem_busy, exc_req, exc_stage,
    output stall_o, flush_o, exc_redirect, exc_busy
  );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_exc_flush_fsm.sv
// Precise-exception sequencer: latches the oldest faulting stage, waits out memory
// traffic in DRAIN, then holds FLUSH for FLUSH_CYCLES with a one-cycle redirect pulse.
module exc_flush_fsm
  import gemini_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles,
  parameter int unsigned SW           = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exc_req,
  input  logic [SW-1:0] exc_stage,
  input  logic          mem_busy,
  output exc_state_e    state,
  output logic [SW-1:0] lat_stage,
  output logic          exc_redirect,
  output logic          exc_busy
);

  localparam logic [3:0] CntInit = 4'(FLUSH_CYCLES - 1);

  exc_state_e    state_q, state_d;
  logic [SW-1:0] lat_q, lat_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          redir_q, redir_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (exc_req) begin
          lat_d = exc_stage;
          if (mem_busy) begin
            state_d = StDrain;
          end else begin
            state_d = StFlush;
            cnt_d   = CntInit;
            redir_d = 1'b1;
          end
        end
      end
      StDrain: begin
        // An older (higher-index) exception supersedes the one being drained.
        if (exc_req && (exc_stage > lat_q)) lat_d = exc_stage;
        if (!mem_busy) begin
          state_d = StFlush;
          cnt_d   = CntInit;
          redir_d = 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
      cnt_q   <= '0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
    end
  end

  assign state        = state_q;
  assign lat_stage    = lat_q;
  assign exc_redirect = redir_q;
  assign exc_busy     = (state_q != StIdle);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised stall/bubble/branch-flush resolver with precise-exception sequencing.
// Define STALL_WDOG_EN to add the sticky stall watchdog (wdog_trip).
module pipe_hazard_ctrl
  import gemini_ctrl_pkg::*;
#(
  parameter int unsigned STAGES       = DefStages,
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned SW = stage_w(STAGES);

  if (STAGES < 3 || STAGES > 16 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDOG_LIMIT < 1)
  begin : g_param_check
    $error("pipe_hazard_ctrl: parameter out of legal range");
  end

  exc_state_e        state;
  logic [SW-1:0]     lat_stage;
  logic [STAGES-1:0] lat_mask;
  logic [STAGES-1:0] stall_v;
  logic [STAGES-1:0] flush_v;
  logic              acc;
  logic              honour;

  exc_flush_fsm #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .SW           (SW)
  ) u_exc_flush_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .exc_req      (bus.exc_req),
    .exc_stage    (bus.exc_stage),
    .mem_busy     (bus.mem_busy),
    .state        (state),
    .lat_stage    (lat_stage),
    .exc_redirect (bus.exc_redirect),
    .exc_busy     (bus.exc_busy)
  );

  always_comb begin
    stall_v  = '0;
    flush_v  = '0;
    lat_mask = '0;
    acc      = 1'b0;
    honour   = 1'b0;
    // Stalls propagate from the oldest stage down towards fetch.
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc         = acc | bus.stall_req[i];
      lat_mask[i] = (i <= int'(lat_stage));
      stall_v[i]  = acc | ((state == StDrain) && lat_mask[i]);
      if ((state == StFlush) && lat_mask[i]) stall_v[i] = 1'b0;
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      flush_v[i+1] = stall_v[i] & ~stall_v[i+1];
    end
    // Honoured requests nest (lower k flushes a subset), so OR-ing them equals highest-k wins.
    for (int k = 0; k < STAGES; k++) begin
      honour = bus.br_flush_req[k] & ~stall_v[k] & (state != StFlush) &
               ~((state == StDrain) & lat_mask[k]);
      for (int j = 1; j < k; j++) begin
        if (honour) flush_v[j] = 1'b1;
      end
    end
    if (state == StFlush) flush_v = flush_v | lat_mask;
    if (!rst_n) begin
      stall_v = '0;
      flush_v = '0;
    end
  end

  assign bus.stall_o = stall_v;
  assign bus.flush_o = flush_v;

`ifdef STALL_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WdogMax = WW'(WDOG_LIMIT);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_trip_q;

  always_comb begin
    wdog_cnt_d = '0;
    if (stall_v[STAGES-1]) begin
      wdog_cnt_d = (wdog_cnt_q == WdogMax) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_q | (wdog_cnt_d == WdogMax);
    end
  end

  assign bus.wdog_trip = wdog_trip_q;
`endif

endmodule
